// File: rtl/loongson_dmem_responder.sv
// Memory-side responder for the MEM-stage data access handshake: accepts one
// load/store, waits LATENCY cycles, then performs the access on a word RAM.
module loongson_dmem_responder #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_MemWr,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [3:0]        req_be,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_busy,
    output logic              mem_done,
    output logic              mem_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] LP_CNT_INIT = 4'(LATENCY - 1);
    localparam int         LP_DEPTH    = 1 << ADDR_W;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_is_load;
    logic [ADDR_W+1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [3:0]          r_be;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [DATA_W-1:0]   r_mem [LP_DEPTH];

    logic                w_req_store;
    logic                w_req_load;
    logic [ADDR_W-1:0]   w_word;
    logic                w_misalign;
    logic                w_fire;
    logic                w_wr_en;
    logic                w_rd_en;

    // Opcode 11 is reserved and decodes to neither operation, i.e. idle.
    assign w_req_store = (req_MemWr == 2'b01);
    assign w_req_load  = (req_MemWr == 2'b10);
    assign w_word      = r_addr[ADDR_W+1:2];
    assign w_misalign  = (r_addr[1:0] != 2'b00);
    assign w_fire      = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_wr_en     = w_fire && !r_is_load && !w_misalign;
    assign w_rd_en     = w_fire &&  r_is_load && !w_misalign;

    // RAM contents survive reset; only the byte lanes enabled by r_be change.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    r_mem[w_word][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_is_load <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= 4'd0;
            r_rdata   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
                    if (w_req_store || w_req_load) begin
                        r_is_load <= w_req_load;
                        r_addr    <= req_addr[ADDR_W+1:0];
                        r_wdata   <= req_wdata;
                        r_be      <= req_be;
                        r_cnt     <= LP_CNT_INIT;
                        r_busy    <= 1'b1;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (w_rd_en) begin
                            r_rdata <= r_mem[w_word];
                        end
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= w_misalign;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Requests seen here are deliberately dropped; the
                    // initiator re-presents them once we are back in IDLE.
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_rdata = r_rdata;
    assign mem_busy  = r_busy;
    assign mem_done  = r_done;
    assign mem_err   = r_err;

endmodule

// File: tb/tb_loongson_dmem_responder.sv
// Directed bench for loongson_dmem_responder at LATENCY=2, ADDR_W=8.
module tb_loongson_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_MemWr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic [31:0] mem_rdata;
    logic        mem_busy;
    logic        mem_done;
    logic        mem_err;

    int n_checks = 0;
    int n_fail   = 0;

    loongson_dmem_responder #(
        .DATA_W (32),
        .ADDR_W (8),
        .LATENCY(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_MemWr(req_MemWr),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_be   (req_be),
        .mem_rdata(mem_rdata),
        .mem_busy (mem_busy),
        .mem_done (mem_done),
        .mem_err  (mem_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver: presents one request for a single edge, then observes the
    // transaction until the done pulse has come and gone (bounded).
    task automatic run_req(input logic [1:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           output int busy_n, output int done_n,
                           output logic err_done, output logic [31:0] rd_done,
                           output logic [31:0] rd_after, output logic err_after,
                           output bit timeout);
        busy_n   = 0;
        done_n   = 0;
        err_done = 1'b0;
        rd_done  = '0;
        timeout  = 1'b1;
        req_MemWr = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        tick();
        req_MemWr = 2'b00;
        for (int c = 0; c < 20; c++) begin
            if (done_n > 0 && !mem_done) begin
                timeout = 1'b0;
                break;
            end
            if (mem_busy) busy_n++;
            if (mem_done) begin
                done_n++;
                err_done = mem_err;
                rd_done  = mem_rdata;
            end
            tick();
        end
        rd_after  = mem_rdata;
        err_after = mem_err;
    endtask

    task automatic test_reset();
        int act;
        rst_n     = 1'b0;
        req_MemWr = 2'b10;
        req_addr  = 32'h10;
        req_wdata = 32'h0;
        req_be    = 4'hF;
        repeat (3) tick();
        n_checks++;
        if (mem_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", mem_busy); end
        n_checks++;
        if (mem_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", mem_done); end
        n_checks++;
        if (mem_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", mem_err); end
        n_checks++;
        if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00000000", mem_rdata); end
        req_MemWr = 2'b00;
        rst_n     = 1'b1;
        act = 0;
        repeat (5) begin
            tick();
            if (mem_busy || mem_done) act++;
        end
        n_checks++;
        if (act !== 0) begin n_fail++; $display("FAIL reset_idle_activity: got %0d cycles expected 0", act); end
    endtask

    task automatic test_store_load();
        int b, d; logic e, ea; logic [31:0] rd, ra; bit to;
        run_req(2'b01, 32'h10, 32'hDEADBEEF, 4'hF, b, d, e, rd, ra, ea, to);
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL store_timeout: got %b expected 0", to); end
        n_checks++;
        if (b !== 2) begin n_fail++; $display("FAIL store_busy_cycles: got %0d expected 2", b); end
        n_checks++;
        if (d !== 1) begin n_fail++; $display("FAIL store_done_cycles: got %0d expected 1", d); end
        n_checks++;
        if (e !== 1'b0) begin n_fail++; $display("FAIL store_err: got %b expected 0", e); end
        run_req(2'b10, 32'h10, 32'h0, 4'h0, b, d, e, rd, ra, ea, to);
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL load_timeout: got %b expected 0", to); end
        n_checks++;
        if (b !== 2) begin n_fail++; $display("FAIL load_busy_cycles: got %0d expected 2", b); end
        n_checks++;
        if (d !== 1) begin n_fail++; $display("FAIL load_done_cycles: got %0d expected 1", d); end
        n_checks++;
        if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_rdata_done: got %h expected deadbeef", rd); end
        n_checks++;
        if (ra !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_rdata_held: got %h expected deadbeef", ra); end
        n_checks++;
        if (ea !== 1'b0) begin n_fail++; $display("FAIL load_err_after: got %b expected 0", ea); end
    endtask

    task automatic test_byte_enables();
        int b, d; logic e, ea; logic [31:0] rd, ra; bit to;
        run_req(2'b01, 32'h10, 32'h0000AA00, 4'b0010, b, d, e, rd, ra, ea, to);
        n_checks++;
        if (ra !== 32'hDEADBEEF) begin n_fail++; $display("FAIL be_store_keeps_rdata: got %h expected deadbeef", ra); end
        run_req(2'b10, 32'h10, 32'h0, 4'h0, b, d, e, rd, ra, ea, to);
        n_checks++;
        if (rd !== 32'hDEADAAEF) begin n_fail++; $display("FAIL be_byte1_merge: got %h expected deadaaef", rd); end
        run_req(2'b01, 32'h10, 32'h55555555, 4'b0000, b, d, e, rd, ra, ea, to);
        n_checks++;
        if (d !== 1) begin n_fail++; $display("FAIL be_zero_done: got %0d expected 1", d); end
        run_req(2'b10, 32'h10, 32'h0, 4'h0, b, d, e, rd, ra, ea, to);
        n_checks++;
        if (rd !== 32'hDEADAAEF) begin n_fail++; $display("FAIL be_zero_nochange: got %h expected deadaaef", rd); end
    endtask

    task automatic test_misaligned();
        int b, d; logic e, ea; logic [31:0] rd, ra; bit to;
        run_req(2'b10, 32'h13, 32'h0, 4'h0, b, d, e, rd, ra, ea, to);
        n_checks++;
        if (e !== 1'b1) begin n_fail++; $display("FAIL mis_load_err: got %b expected 1", e); end
        n_checks++;
        if (b !== 2) begin n_fail++; $display("FAIL mis_load_busy_cycles: got %0d expected 2", b); end
        n_checks++;
        if (rd !== 32'hDEADAAEF) begin n_fail++; $display("FAIL mis_load_rdata: got %h expected deadaaef", rd); end
        n_checks++;
        if (ea !== 1'b0) begin n_fail++; $display("FAIL mis_err_drop: got %b expected 0", ea); end
        run_req(2'b01, 32'h12, 32'h12345678, 4'hF, b, d, e, rd, ra, ea, to);
        n_checks++;
        if (e !== 1'b1) begin n_fail++; $display("FAIL mis_store_err: got %b expected 1", e); end
        run_req(2'b10, 32'h10, 32'h0, 4'h0, b, d, e, rd, ra, ea, to);
        n_checks++;
        if (rd !== 32'hDEADAAEF) begin n_fail++; $display("FAIL mis_store_nowrite: got %h expected deadaaef", rd); end
        n_checks++;
        if (e !== 1'b0) begin n_fail++; $display("FAIL aligned_load_err: got %b expected 0", e); end
    endtask

    task automatic test_reset_mid();
        int b, d; logic e, ea; logic [31:0] rd, ra; bit to;
        run_req(2'b01, 32'h20, 32'h11111111, 4'hF, b, d, e, rd, ra, ea, to);
        req_MemWr = 2'b01;
        req_addr  = 32'h20;
        req_wdata = 32'h22222222;
        req_be    = 4'hF;
        tick();
        req_MemWr = 2'b00;
        n_checks++;
        if (mem_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before_reset: got %b expected 1", mem_busy); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy_after_reset: got %b expected 0", mem_busy); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_req(2'b10, 32'h20, 32'h0, 4'h0, b, d, e, rd, ra, ea, to);
        n_checks++;
        if (rd !== 32'h11111111) begin n_fail++; $display("FAIL mid_reset_aborted_store: got %h expected 11111111", rd); end
    endtask

    task automatic test_alias();
        int b, d; logic e, ea; logic [31:0] rd, ra; bit to;
        run_req(2'b01, 32'h400, 32'hCAFEF00D, 4'hF, b, d, e, rd, ra, ea, to);
        run_req(2'b10, 32'h000, 32'h0, 4'h0, b, d, e, rd, ra, ea, to);
        n_checks++;
        if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL alias_load: got %h expected cafef00d", rd); end
    endtask

    task automatic test_reserved();
        int act;
        act = 0;
        req_MemWr = 2'b11;
        repeat (4) begin
            tick();
            if (mem_busy || mem_done) act++;
        end
        req_MemWr = 2'b00;
        tick();
        if (mem_busy || mem_done) act++;
        n_checks++;
        if (act !== 0) begin n_fail++; $display("FAIL reserved_opcode_activity: got %0d cycles expected 0", act); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] busy_pat, done_pat;
        busy_pat = '0;
        done_pat = '0;
        req_MemWr = 2'b10;
        req_addr  = 32'h0;
        for (int i = 0; i < 7; i++) begin
            tick();
            busy_pat[i] = mem_busy;
            done_pat[i] = mem_done;
        end
        req_MemWr = 2'b00;
        tick();
        tick();
        n_checks++;
        if (busy_pat !== 7'b0110011) begin n_fail++; $display("FAIL held_req_busy_pattern: got %b expected 0110011", busy_pat); end
        n_checks++;
        if (done_pat !== 7'b1000100) begin n_fail++; $display("FAIL held_req_done_pattern: got %b expected 1000100", done_pat); end
        n_checks++;
        if (mem_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL held_req_rdata: got %h expected cafef00d", mem_rdata); end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_MemWr = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        test_reset();
        test_store_load();
        test_byte_enables();
        test_misaligned();
        test_reset_mid();
        test_alias();
        test_reserved();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
